// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - 4:1 mux scan sequencer, serial-to-parallel capture with valid/ready output
// Optional MUX_SCAN_AUTO_EN: HOLD exits straight into a fresh scan on ready, so scans run back-to-back.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic [1:0] sel,
    input  logic       mux_dout,
    output logic [3:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [3:0] shadow, shadow_n;
    logic [3:0] data_n;
    logic [1:0] sel_n;
    logic       valid_n, busy_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 8'd0;
            shadow <= 4'd0;
            sel    <= 2'd0;
            data   <= 4'd0;
            valid  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            shadow <= shadow_n;
            sel    <= sel_n;
            data   <= data_n;
            valid  <= valid_n;
            busy   <= busy_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        shadow_n = shadow;
        sel_n    = sel;
        data_n   = data;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n  = SCAN;
                    sel_n    = 2'd0;
                    cnt_n    = SETTLE_CNT;
                    shadow_n = 4'd0;
                end
            end
            SCAN: begin
                // abort wins over a sample landing on the same edge
                if (abort) begin
                    state_n = IDLE;
                    sel_n   = 2'd0;
                end else if (cnt != 8'd0) begin
                    cnt_n = cnt - 8'd1;
                end else begin
                    shadow_n[sel] = mux_dout;
                    if (sel != 2'd3) begin
                        sel_n = sel + 2'd1;
                        cnt_n = SETTLE_CNT;
                    end else begin
                        data_n  = {mux_dout, shadow[2:0]};
                        state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                if (ready) begin
                    sel_n = 2'd0;
`ifdef MUX_SCAN_AUTO_EN
                    state_n  = SCAN;
                    cnt_n    = SETTLE_CNT;
                    shadow_n = 4'd0;
`else
                    state_n = IDLE;
`endif
                end
            end
            default: begin
                state_n = IDLE;
                sel_n   = 2'd0;
            end
        endcase
        // flags registered from the next state so they line up with it
        valid_n = (state_n == HOLD);
        busy_n  = (state_n != IDLE);
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - randomized directed bench for mux_scan_ctrl, two instances (SETTLE=2 and SETTLE=0)
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a    [2];
    logic       abort_a    [2];
    logic       ready_a    [2];
    logic       mux_dout_a [2];
    logic       valid_a    [2];
    logic       busy_a     [2];
    logic [1:0] sel_a      [2];
    logic [3:0] data_a     [2];
    logic [3:0] din_a      [2];
    logic [3:0] exp_data   [2];
    int         n_assert = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    assign mux_dout_a[0] = din_a[0][sel_a[0]];
    assign mux_dout_a[1] = din_a[1][sel_a[1]];

    mux_scan_ctrl #(.SETTLE(2)) dut_s2 (
        .clk(clk), .rst(rst), .start(start_a[0]), .abort(abort_a[0]),
        .sel(sel_a[0]), .mux_dout(mux_dout_a[0]), .data(data_a[0]),
        .valid(valid_a[0]), .ready(ready_a[0]), .busy(busy_a[0])
    );

    mux_scan_ctrl #(.SETTLE(0)) dut_s0 (
        .clk(clk), .rst(rst), .start(start_a[1]), .abort(abort_a[1]),
        .sel(sel_a[1]), .mux_dout(mux_dout_a[1]), .data(data_a[1]),
        .valid(valid_a[1]), .ready(ready_a[1]), .busy(busy_a[1])
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input int d, input string tag, input logic [1:0] s,
                              input logic v, input logic b, input logic [3:0] w);
        check({tag, ".sel"},   32'(sel_a[d]),   32'(s));
        check({tag, ".valid"}, 32'(valid_a[d]), 32'(v));
        check({tag, ".busy"},  32'(busy_a[d]),  32'(b));
        check({tag, ".data"},  32'(data_a[d]),  32'(w));
    endtask

    task automatic idle_inputs(input int d);
        start_a[d] = 1'b0;
        abort_a[d] = 1'b0;
        ready_a[d] = 1'b0;
    endtask

    // One scan: start at edge 0; channel i is sampled at edge (i+1)*p with p = SETTLE+1,
    // so its expected bit is whatever din[i] was driven just before that edge.
    task automatic run_scan(input int d, input int hold, input int abort_at);
        int         p;
        logic [3:0] exp_w;
        p     = (d == 0) ? 3 : 1;
        exp_w = 4'd0;
        for (int k = 0; k <= 4 * p; k++) begin
            if (k > 0) din_a[d] = 4'($urandom);
            start_a[d] = (k == 0) ? 1'b1 : 1'($urandom);
            ready_a[d] = 1'($urandom);
            abort_a[d] = (k == abort_at);
            if (k > 0 && (k % p) == 0) exp_w[k / p - 1] = din_a[d][k / p - 1];
            tick;
            if (k == abort_at) begin
                check_outs(d, "abort", 2'd0, 1'b0, 1'b0, exp_data[d]);
                idle_inputs(d);
                tick;
                check_outs(d, "post_abort", 2'd0, 1'b0, 1'b0, exp_data[d]);
                return;
            end
            if (k < 4 * p)
                check_outs(d, "scan", 2'(k / p), 1'b0, 1'b1, exp_data[d]);
            else
                check_outs(d, "done", 2'd3, 1'b1, 1'b1, exp_w);
        end
        exp_data[d] = exp_w;
        for (int h = 0; h < hold; h++) begin
            ready_a[d] = 1'b0;
            start_a[d] = (h == 1) ? 1'b1 : 1'($urandom);
            abort_a[d] = 1'($urandom);
            din_a[d]   = 4'($urandom);
            tick;
            check_outs(d, "hold", 2'd3, 1'b1, 1'b1, exp_data[d]);
        end
        ready_a[d] = 1'b1;
        start_a[d] = 1'($urandom);
        abort_a[d] = 1'b0;
        tick;
`ifdef MUX_SCAN_AUTO_EN
        check_outs(d, "reload", 2'd0, 1'b0, 1'b1, exp_data[d]);
        idle_inputs(d);
        abort_a[d] = 1'b1;
        tick;
        check_outs(d, "stop", 2'd0, 1'b0, 1'b0, exp_data[d]);
`else
        check_outs(d, "release", 2'd0, 1'b0, 1'b0, exp_data[d]);
        idle_inputs(d);
        tick;
        check_outs(d, "idle", 2'd0, 1'b0, 1'b0, exp_data[d]);
`endif
        idle_inputs(d);
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            idle_inputs(d);
            din_a[d]    = 4'd0;
            exp_data[d] = 4'd0;
        end
        tick;
        tick;
        check_outs(0, "reset", 2'd0, 1'b0, 1'b0, 4'd0);
        check_outs(1, "reset", 2'd0, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        tick;

        run_scan(0, 0, -1);
        run_scan(0, 5, -1);
        for (int i = 0; i < 4; i++) run_scan(0, int'($urandom_range(0, 4)), -1);
        run_scan(0, 0, 5);
        run_scan(0, 0, 12);
        run_scan(0, 2, -1);

        for (int i = 0; i < 6; i++) run_scan(1, int'($urandom_range(0, 3)), -1);
        run_scan(1, 0, 2);
        run_scan(1, 0, 4);
        run_scan(1, 1, -1);

        // asynchronous reset between edges while instance 0 is on channel 2
        start_a[0] = 1'b1;
        din_a[0]   = 4'($urandom);
        tick;
        start_a[0] = 1'b0;
        for (int k = 1; k <= 6; k++) tick;
        check("pre_reset.sel", 32'(sel_a[0]), 32'd2);
        #3;
        rst = 1'b1;
        #1;
        check_outs(0, "async_rst", 2'd0, 1'b0, 1'b0, 4'd0);
        check_outs(1, "async_rst", 2'd0, 1'b0, 1'b0, 4'd0);
        tick;
        check_outs(0, "rst_edge", 2'd0, 1'b0, 1'b0, 4'd0);
        check_outs(1, "rst_edge", 2'd0, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_data[0] = 4'd0;
        exp_data[1] = 4'd0;
        tick;
        run_scan(0, 1, -1);

`ifdef MUX_SCAN_AUTO_EN
        // one start, ready held high: words complete every 4*p+1 edges with p=1
        din_a[1]   = 4'($urandom);
        ready_a[1] = 1'b1;
        start_a[1] = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick;
            start_a[1] = 1'b0;
            check("auto.valid", 32'(valid_a[1]), 32'((k % 5) == 4));
            check("auto.busy",  32'(busy_a[1]),  32'd1);
            if ((k % 5) == 4) check("auto.data", 32'(data_a[1]), 32'(din_a[1]));
        end
        exp_data[1] = din_a[1];
        abort_a[1]  = 1'b1;
        tick;
        idle_inputs(1);
        check_outs(1, "auto_stop", 2'd0, 1'b0, 1'b0, exp_data[1]);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
